// File: rtl/present_anim_ctrl.sv
// Present sprite animation sequencer and ROM pixel pipeline; PRESENT_ANIM_PINGPONG_EN makes looping bounce.
// Latency: beam position to pixel_valid/pixel_index is 3 Clk cycles; frame_clk edge to tick is 3 Clk cycles.
// Backpressure: none, the pixel pipeline never stalls and start/stop are single-cycle pulses.
module present_anim_ctrl #(
    parameter int SPR_W           = 108,
    parameter int SPR_H           = 108,
    parameter int NUM_FRAMES      = 6,
    parameter int TICKS_PER_FRAME = 4,
    parameter int TRANSPARENT     = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [13:0] rom_addr,
    output logic [2:0]  rom_cs,
    input  logic [2:0]  rom_data,
    output logic        pixel_valid,
    output logic [2:0]  pixel_index,
    output logic        busy,
    output logic        done
);

    localparam int TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_FRAME - 1);
    localparam logic [2:0]    LAST      = 3'(NUM_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, PLAY, HOLD} state_t;

    state_t        state_q, state_d;
    logic [2:0]    frame_q, frame_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          done_q, done_d;
    logic          fc_meta_q, fc_sync_q, fc_prev_q;
    logic          tick;
`ifdef PRESENT_ANIM_PINGPONG_EN
    logic          dir_down_q, dir_down_d;
`endif

    // frame_clk is asynchronous: two flops for metastability, a third for edge detection
    assign tick = fc_sync_q & ~fc_prev_q;

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        tick_cnt_d = tick_cnt_q;
        done_d     = 1'b0;
`ifdef PRESENT_ANIM_PINGPONG_EN
        dir_down_d = dir_down_q;
`endif
        if (stop) begin
            state_d    = IDLE;
            frame_d    = '0;
            tick_cnt_d = '0;
`ifdef PRESENT_ANIM_PINGPONG_EN
            dir_down_d = 1'b0;
`endif
        end else if (start) begin
            state_d    = PLAY;
            frame_d    = '0;
            tick_cnt_d = '0;
`ifdef PRESENT_ANIM_PINGPONG_EN
            dir_down_d = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: frame_d = '0;
                PLAY: begin
                    if (tick) begin
                        if (tick_cnt_q == TICK_LAST) begin
                            tick_cnt_d = '0;
`ifdef PRESENT_ANIM_PINGPONG_EN
                            if (loop_en) begin
                                if (!dir_down_q) begin
                                    if (frame_q < LAST) begin
                                        frame_d = frame_q + 3'd1;
                                    end else begin
                                        frame_d    = frame_q - 3'd1;
                                        dir_down_d = 1'b1;
                                    end
                                end else if (frame_q != 3'd0) begin
                                    frame_d = frame_q - 3'd1;
                                end else begin
                                    frame_d    = 3'd1;
                                    dir_down_d = 1'b0;
                                end
                            end else if (frame_q < LAST) begin
                                frame_d    = frame_q + 3'd1;
                                dir_down_d = 1'b0;
                            end else begin
                                state_d = HOLD;
                                done_d  = 1'b1;
                            end
`else
                            if (frame_q < LAST) begin
                                frame_d = frame_q + 3'd1;
                            end else if (loop_en) begin
                                frame_d = '0;
                            end else begin
                                state_d = HOLD;
                                done_d  = 1'b1;
                            end
`endif
                        end else begin
                            tick_cnt_d = tick_cnt_q + TW'(1);
                        end
                    end
                end
                HOLD: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            tick_cnt_q <= '0;
            done_q     <= 1'b0;
            fc_meta_q  <= 1'b0;
            fc_sync_q  <= 1'b0;
            fc_prev_q  <= 1'b0;
`ifdef PRESENT_ANIM_PINGPONG_EN
            dir_down_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            tick_cnt_q <= tick_cnt_d;
            done_q     <= done_d;
            fc_meta_q  <= frame_clk;
            fc_sync_q  <= fc_meta_q;
            fc_prev_q  <= fc_sync_q;
`ifdef PRESENT_ANIM_PINGPONG_EN
            dir_down_q <= dir_down_d;
`endif
        end
    end

    assign rom_cs = frame_q;
    assign busy   = (state_q == PLAY);
    assign done   = done_q;

    // 11-bit bounds keep sprites near the right/bottom edge from wrapping
    logic [10:0] x_hi, y_hi;
    logic [9:0]  rel_x, rel_y;
    logic        inside_d;
    logic [13:0] rom_addr_d, rom_addr_q;
    logic        inside_q, inside_d2_q;
    logic        pixel_valid_q;
    logic [2:0]  pixel_index_q;

    assign x_hi     = {1'b0, sprite_x} + 11'(SPR_W);
    assign y_hi     = {1'b0, sprite_y} + 11'(SPR_H);
    assign inside_d = (DrawX >= sprite_x) && ({1'b0, DrawX} < x_hi) &&
                      (DrawY >= sprite_y) && ({1'b0, DrawY} < y_hi);
    assign rel_x    = DrawX - sprite_x;
    assign rel_y    = DrawY - sprite_y;
    assign rom_addr_d = inside_d ? (14'(rel_y) * 14'(SPR_W) + 14'(rel_x)) : 14'd0;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr_q    <= '0;
            inside_q      <= 1'b0;
            inside_d2_q   <= 1'b0;
            pixel_valid_q <= 1'b0;
            pixel_index_q <= '0;
        end else begin
            rom_addr_q    <= rom_addr_d;
            inside_q      <= inside_d;
            inside_d2_q   <= inside_q;
            pixel_index_q <= rom_data;
            pixel_valid_q <= inside_d2_q && (rom_data != 3'(TRANSPARENT));
        end
    end

    assign rom_addr    = rom_addr_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_index = pixel_index_q;

endmodule

// File: tb/tb_present_anim_ctrl.sv
// Directed bench for present_anim_ctrl: address mapping, transparency, one-shot, loop, collisions, reset.
module tb_present_anim_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [9:0]  sprite_x = 10'd100;
    logic [9:0]  sprite_y = 10'd50;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic [13:0] rom_addr;
    logic [2:0]  rom_cs;
    logic [2:0]  rom_data = 3'd0;
    logic [2:0]  rom_val = 3'd0;
    logic        pixel_valid;
    logic [2:0]  pixel_index;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int base;

    present_anim_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start), .stop(stop),
        .loop_en(loop_en), .sprite_x(sprite_x), .sprite_y(sprite_y), .DrawX(DrawX), .DrawY(DrawY),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .pixel_valid(pixel_valid),
        .pixel_index(pixel_index), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    // sprite ROM stub: one-cycle registered read of whatever value the bench selects
    always @(posedge Clk) rom_data <= rom_val;

    always @(negedge Clk) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_fc();
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        @(negedge Clk);
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge Clk);
        stop = 1'b0;
        @(negedge Clk);
    endtask

    task automatic beam(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(negedge Clk);
    endtask

    function automatic int exp_loop(input int k);
`ifdef PRESENT_ANIM_PINGPONG_EN
        int m;
        m = k % 10;
        return (m <= 5) ? m : 10 - m;
`else
        return k % 6;
`endif
    endfunction

    initial begin
        repeat (5) @(negedge Clk);
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_cs", int'(rom_cs), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pv", int'(pixel_valid), 0);
        Reset = 1'b0;
        @(negedge Clk);

        // address mapping
        beam(100, 50);  chk("addr_origin", int'(rom_addr), 0);
        beam(110, 52);  chk("addr_mid", int'(rom_addr), 226);
        beam(207, 157); chk("addr_max", int'(rom_addr), 11663);
        beam(99, 50);   chk("addr_left", int'(rom_addr), 0);
        beam(150, 158); chk("addr_below", int'(rom_addr), 0);
        sprite_x = 10'd1000;
        beam(1023, 50); chk("addr_wrap", int'(rom_addr), 23);
        sprite_x = 10'd100;

        // pixel latency and transparency
        rom_val = 3'd5;
        repeat (4) beam(0, 0);
        chk("pv_out", int'(pixel_valid), 0);
        beam(150, 100); chk("pv_lat1", int'(pixel_valid), 0);
        @(negedge Clk); chk("pv_lat2", int'(pixel_valid), 0);
        @(negedge Clk); chk("pv_lat3", int'(pixel_valid), 1);
        chk("pidx_lat3", int'(pixel_index), 5);
        rom_val = 3'd0;
        repeat (4) @(negedge Clk);
        chk("pv_transp", int'(pixel_valid), 0);
        chk("pidx_transp", int'(pixel_index), 0);
        rom_val = 3'd5;
        beam(208, 100);
        repeat (2) @(negedge Clk);
        chk("pv_right_edge", int'(pixel_valid), 0);
        beam(0, 0);

        // one-shot playback
        loop_en = 1'b0;
        pulse_start();
        chk("os_busy0", int'(busy), 1);
        chk("os_cs0", int'(rom_cs), 0);
        for (int p = 1; p <= 24; p++) begin
            pulse_fc();
            chk($sformatf("os_cs_p%0d", p), int'(rom_cs), (p < 24) ? p / 4 : 5);
            chk($sformatf("os_done_p%0d", p), done_cnt, (p == 24) ? 1 : 0);
        end
        chk("os_busy_end", int'(busy), 0);
        repeat (8) pulse_fc();
        chk("os_hold_cs", int'(rom_cs), 5);
        chk("os_hold_done", done_cnt, 1);

        // looping playback
        loop_en = 1'b1;
        pulse_start();
        chk("lp_cs0", int'(rom_cs), 0);
        for (int p = 1; p <= 30; p++) begin
            pulse_fc();
            chk($sformatf("lp_cs_p%0d", p), int'(rom_cs), exp_loop(p / 4));
        end
        chk("lp_busy", int'(busy), 1);
        chk("lp_no_done", done_cnt, 1);
        pulse_stop();
        chk("lp_stop_cs", int'(rom_cs), 0);
        chk("lp_stop_busy", int'(busy), 0);

        // start/stop collisions
        pulse_start();
        repeat (5) pulse_fc();
        chk("col_cs1", int'(rom_cs), 1);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        stop  = 1'b0;
        @(negedge Clk);
        chk("col_busy", int'(busy), 0);
        chk("col_cs", int'(rom_cs), 0);
        pulse_start();
        repeat (13) pulse_fc();
        chk("rs_cs3", int'(rom_cs), 3);
        pulse_start();
        chk("rs_cs0", int'(rom_cs), 0);
        chk("rs_busy", int'(busy), 1);
        repeat (3) pulse_fc();
        chk("rs_cnt3", int'(rom_cs), 0);
        pulse_fc();
        chk("rs_cnt4", int'(rom_cs), 1);

        // reset mid-play
        loop_en = 1'b0;
        pulse_start();
        repeat (16) pulse_fc();
        chk("mr_cs4", int'(rom_cs), 4);
        beam(150, 100);
        repeat (3) @(negedge Clk);
        chk("mr_pv_pre", int'(pixel_valid), 1);
        base = done_cnt;
        #2;
        Reset = 1'b1;
        #1;
        chk("mr_cs", int'(rom_cs), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_pv", int'(pixel_valid), 0);
        chk("mr_addr", int'(rom_addr), 0);
        chk("mr_pidx", int'(pixel_index), 0);
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("mr_no_done", done_cnt, base);
        chk("mr_idle_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
